// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources,
// with an optional inter-frame gap and a baud-tick watchdog on the done handshake.
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 3,
  parameter int WORD_BITS     = 8,
  parameter int GAP_TICKS     = 0,
  parameter int TIMEOUT_TICKS = 4096
)(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         baud_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*WORD_BITS-1:0] data_i,
  output logic [NUM_REQ-1:0]           ack_o,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         busy_o,
  output logic                         timeout_o,
  output logic                         tx_start_o,
  output logic [WORD_BITS-1:0]         tx_data_o,
  input  logic                         tx_done_i
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_TICKS - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_TICKS);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t                 r_state, w_state_n;
  logic [NUM_REQ-1:0]     r_grant, w_grant_n, r_ack, w_ack_n;
  logic [WORD_BITS-1:0]   r_data, w_data_n;
  logic [PW-1:0]          r_ptr, w_ptr_n, w_win, w_idx;
  logic [WW-1:0]          r_wd, w_wd_n;
  logic [GW-1:0]          r_gap, w_gap_n;
  logic                   r_tout, w_tout_n, r_start, w_start_n, r_busy, w_busy_n;
  logic                   w_found;

  // First requester strictly after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_data  <= '0;
      r_ptr   <= PTR_RST;
      r_wd    <= '0;
      r_gap   <= '0;
      r_tout  <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_ack   <= w_ack_n;
      r_data  <= w_data_n;
      r_ptr   <= w_ptr_n;
      r_wd    <= w_wd_n;
      r_gap   <= w_gap_n;
      r_tout  <= w_tout_n;
      r_start <= w_start_n;
      r_busy  <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_data_n  = r_data;
    w_ptr_n   = r_ptr;
    w_wd_n    = r_wd;
    w_gap_n   = r_gap;
    w_ack_n   = '0;
    w_tout_n  = 1'b0;
    w_start_n = 1'b0;
    case (r_state)
      IDLE: if (w_found) begin
        w_state_n = START;
        w_grant_n = NUM_REQ'(1) << w_win;
        w_data_n  = data_i[w_win*WORD_BITS +: WORD_BITS];
        w_ptr_n   = w_win;
      end
      START: begin
        w_start_n = 1'b1;
        w_wd_n    = '0;
        w_state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done wins over an abort landing on the same cycle
        if (tx_done_i) begin
          w_ack_n   = r_grant;
          w_gap_n   = '0;
          w_state_n = GAP;
        end else if (baud_i) begin
          if (r_wd == WD_LAST) begin
            w_ack_n   = r_grant;
            w_tout_n  = 1'b1;
            w_gap_n   = '0;
            w_state_n = GAP;
          end else begin
            w_wd_n = r_wd + 1'b1;
          end
        end
      end
      GAP: begin
        if (r_gap == GAP_END) begin
          w_state_n = IDLE;
          w_grant_n = '0;
        end else if (baud_i) begin
          w_gap_n = r_gap + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
    w_busy_n = (w_state_n != IDLE);
  end

  assign ack_o      = r_ack;
  assign grant_o    = r_grant;
  assign busy_o     = r_busy;
  assign timeout_o  = r_tout;
  assign tx_start_o = r_start;
  assign tx_data_o  = r_data;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Cycle-accurate directed bench for uart_tx_scheduler; the bench plays the transmitter
// and baud source so done/timeout timing is fully controlled.
module tb_uart_tx_scheduler;
  localparam int NR = 3;
  localparam int WB = 8;

  logic            clk_i = 1'b0, reset_i = 1'b0, baud_i = 1'b0, tx_done_i = 1'b0;
  logic [NR-1:0]   req_i = '0;
  logic [NR*WB-1:0] data_i = {8'hC3, 8'hB2, 8'hA1};
  logic [NR-1:0]   ack_o, grant_o;
  logic            busy_o, timeout_o, tx_start_o;
  logic [WB-1:0]   tx_data_o;
  int              checks = 0, failures = 0;

  always #5 clk_i = ~clk_i;

  uart_tx_scheduler #(.NUM_REQ(NR), .WORD_BITS(WB), .GAP_TICKS(2), .TIMEOUT_TICKS(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .baud_i(baud_i), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_done_i(tx_done_i));

  // {grant, ack, busy, start, timeout, tx_data}
  logic [16:0] obs;
  assign obs = {grant_o, ack_o, busy_o, tx_start_o, timeout_o, tx_data_o};

  typedef struct {
    logic [2:0]  req;
    logic        baud;
    logic        done;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs [29];

  function automatic vec_t v(logic [2:0] r, logic b, logic d, logic [2:0] g, logic [2:0] a,
                             logic bz, logic s, logic to, logic [7:0] x);
    vec_t t;
    t.req = r; t.baud = b; t.done = d;
    t.exp = {g, a, bz, s, to, x};
    return t;
  endfunction

  function automatic logic [16:0] e(logic [2:0] g, logic [2:0] a, logic bz, logic s,
                                    logic to, logic [7:0] x);
    return {g, a, bz, s, to, x};
  endfunction

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (grant,ack,busy,start,tout,data)", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // rr pointer resets to 2, so req0 wins first
    vecs[0]  = v(3'b001,0,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[1]  = v(3'b001,0,0, 3'b001,3'b000,1,1,0,8'hA1);
    vecs[2]  = v(3'b001,0,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[3]  = v(3'b000,1,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[4]  = v(3'b000,0,1, 3'b001,3'b001,1,0,0,8'hA1);
    vecs[5]  = v(3'b000,0,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[6]  = v(3'b000,1,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[7]  = v(3'b000,1,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[8]  = v(3'b110,0,0, 3'b000,3'b000,0,0,0,8'hA1);
    vecs[9]  = v(3'b110,0,0, 3'b010,3'b000,1,0,0,8'hB2);
    vecs[10] = v(3'b110,0,0, 3'b010,3'b000,1,1,0,8'hB2);
    vecs[11] = v(3'b110,0,1, 3'b010,3'b010,1,0,0,8'hB2);
    vecs[12] = v(3'b111,1,0, 3'b010,3'b000,1,0,0,8'hB2);
    vecs[13] = v(3'b111,1,0, 3'b010,3'b000,1,0,0,8'hB2);
    vecs[14] = v(3'b111,0,0, 3'b000,3'b000,0,0,0,8'hB2);
    vecs[15] = v(3'b111,0,0, 3'b100,3'b000,1,0,0,8'hC3);
    vecs[16] = v(3'b111,0,0, 3'b100,3'b000,1,1,0,8'hC3);
    vecs[17] = v(3'b111,0,1, 3'b100,3'b100,1,0,0,8'hC3);
    vecs[18] = v(3'b111,1,0, 3'b100,3'b000,1,0,0,8'hC3);
    vecs[19] = v(3'b111,1,0, 3'b100,3'b000,1,0,0,8'hC3);
    vecs[20] = v(3'b111,0,0, 3'b000,3'b000,0,0,0,8'hC3);
    vecs[21] = v(3'b111,0,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[22] = v(3'b000,0,1, 3'b001,3'b000,1,1,0,8'hA1);
    vecs[23] = v(3'b000,0,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[24] = v(3'b000,0,1, 3'b001,3'b001,1,0,0,8'hA1);
    vecs[25] = v(3'b000,0,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[26] = v(3'b000,1,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[27] = v(3'b000,1,0, 3'b001,3'b000,1,0,0,8'hA1);
    vecs[28] = v(3'b000,0,0, 3'b000,3'b000,0,0,0,8'hA1);

    cyc(); cyc();
    check("reset_state", obs, 17'h0);
    reset_i = 1'b1;

    for (int i = 0; i < 29; i++) begin
      req_i = vecs[i].req; baud_i = vecs[i].baud; tx_done_i = vecs[i].done;
      cyc();
      check($sformatf("row%0d", i), obs, vecs[i].exp);
    end

    // watchdog: abort on exactly the 8th baud tick in WAIT_DONE (ptr=0 -> req1 wins)
    req_i = 3'b010; baud_i = 0; tx_done_i = 0;
    cyc(); check("to_grant", obs, e(3'b010,3'b000,1,0,0,8'hB2));
    req_i = 3'b000;
    cyc(); check("to_start", obs, e(3'b010,3'b000,1,1,0,8'hB2));
    baud_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(); check($sformatf("to_tick%0d", k), obs, e(3'b010,3'b000,1,0,0,8'hB2));
    end
    cyc(); check("to_abort", obs, e(3'b010,3'b010,1,0,1,8'hB2));
    baud_i = 1'b0;
    cyc(); check("to_pulse_end", obs, e(3'b010,3'b000,1,0,0,8'hB2));
    baud_i = 1'b1; cyc(); cyc();
    baud_i = 1'b0;
    cyc(); check("to_idle", obs, e(3'b000,3'b000,0,0,0,8'hB2));

    // done coinciding with the terminal tick is a normal completion (ptr=1 -> req2)
    req_i = 3'b100;
    cyc(); check("pri_grant", obs, e(3'b100,3'b000,1,0,0,8'hC3));
    req_i = 3'b000;
    cyc();
    baud_i = 1'b1;
    for (int k = 1; k <= 7; k++) cyc();
    tx_done_i = 1'b1;
    cyc(); check("pri_done_wins", obs, e(3'b100,3'b100,1,0,0,8'hC3));
    tx_done_i = 1'b0;
    cyc(); cyc(); baud_i = 1'b0;
    cyc(); check("pri_idle", obs, e(3'b000,3'b000,0,0,0,8'hC3));

    // reset mid-frame: outputs clear at once, pointer returns to NUM_REQ-1
    req_i = 3'b001;
    cyc(); req_i = 3'b000;
    cyc(); cyc();
    check("mid_wait", obs, e(3'b001,3'b000,1,0,0,8'hA1));
    #2 reset_i = 1'b0;
    #1 check("async_reset", obs, 17'h0);
    tx_done_i = 1'b1;
    cyc(); check("reset_no_ack", obs, 17'h0);
    tx_done_i = 1'b0;
    reset_i = 1'b1;
    req_i = 3'b011;
    cyc(); check("post_reset_grant", obs, e(3'b001,3'b000,1,0,0,8'hA1));
    req_i = 3'b000;
    cyc(); check("post_reset_start", obs, e(3'b001,3'b000,1,1,0,8'hA1));
    tx_done_i = 1'b1;
    cyc(); check("post_reset_ack", obs, e(3'b001,3'b001,1,0,0,8'hA1));
    tx_done_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
